// File: rtl/debug_trace_capture_pkg.sv
// debug_trace_pkg: shared definitions for the debug trace capture buffer.
//   - state_e       : capture FSM encoding, also driven onto the state output
//   - RD_LAT        : cycles from an accepted rd_req to its rd_valid pulse
//   - SRAM_*        : geometry of the SRAM primitive the capture memory is tiled from
//   - clamp_post_len: maps the programmed post-trigger length onto 1..depth
package debug_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam int RD_LAT      = 2;
  localparam int SRAM_DEPTH  = 2048;
  localparam int SRAM_AWIDTH = 11;
  localparam int SRAM_WIDTH  = 8;

  // A post length of 0 still stores the trigger sample; anything longer than
  // the buffer can hold is limited to one full buffer of post-trigger data.
  function automatic logic [31:0] clamp_post_len(input logic [31:0] len,
                                                 input logic [31:0] depth);
    if (len == 32'd0) begin
      return 32'd1;
    end else if (len > depth) begin
      return depth;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/debug_trace_capture_if.sv
// debug_trace_capture_if: control, sample, status and readback signals of the
// trace capture buffer.
//   slave  modport: the capture block (samples/commands in, status/read data out)
//   master modport: the probe mux / register bus side
//
// Readback handshake: there is no ready signal. A cycle with rd_req high is a
// request; it is accepted only while state is IDLE or DONE, otherwise it is
// silently dropped. Every accepted request produces exactly one rd_valid pulse
// RD_LAT (2) cycles later, in request order, with no back-pressure, so
// back-to-back requests give back-to-back rd_valid. rd_data holds its value
// between pulses.
interface debug_trace_capture_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4096
);
  localparam int AWIDTH = $clog2(DEPTH);

  logic              arm;
  logic              abort;
  logic              smp_valid;
  logic [WIDTH-1:0]  smp_data;
  logic              trig;
  logic [AWIDTH:0]   post_len;
  logic [1:0]        state;
  logic              done;
  logic              wrapped;
  logic [AWIDTH:0]   fill_cnt;
  logic [AWIDTH-1:0] trig_addr;
  logic              rd_req;
  logic [AWIDTH-1:0] rd_idx;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data;

  modport slave (
    input  arm, abort, smp_valid, smp_data, trig, post_len, rd_req, rd_idx,
    output state, done, wrapped, fill_cnt, trig_addr, rd_valid, rd_data
  );

  modport master (
    output arm, abort, smp_valid, smp_data, trig, post_len, rd_req, rd_idx,
    input  state, done, wrapped, fill_cnt, trig_addr, rd_valid, rd_data
  );

endinterface

// File: rtl/debug_trace_capture_mem.sv
// trace_sram_2kx8: 2048 x 8 simple dual-port SRAM primitive model. One write
// port and one read port on the same clock; the read address is registered, so
// data for an address presented in cycle N is available during cycle N+1.
//   clk_i, we_i, waddr_i, wdata_i : write port
//   raddr_i, rdata_o              : read port
//
// trace_mem: WIDTH x DEPTH simple dual-port memory with the same timing, built
// from trace_sram_2kx8 tiles: ceil(WIDTH/8) tiles across, ceil(DEPTH/2048) deep.
//   clk_i                           : clock
//   wr_en_i, wr_addr_i, wr_data_i   : write port
//   rd_addr_i, rd_data_o            : read port (registered address)
module trace_sram_2kx8
  import debug_trace_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [SRAM_AWIDTH-1:0] waddr_i,
  input  logic [SRAM_WIDTH-1:0]  wdata_i,
  input  logic [SRAM_AWIDTH-1:0] raddr_i,
  output logic [SRAM_WIDTH-1:0]  rdata_o
);
  logic [SRAM_WIDTH-1:0]  mem_q [SRAM_DEPTH];
  logic [SRAM_AWIDTH-1:0] raddr_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    raddr_q <= raddr_i;
  end

  assign rdata_o = mem_q[raddr_q];
endmodule

module trace_mem
  import debug_trace_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4096
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);
  localparam int AWIDTH = $clog2(DEPTH);
  localparam int NB     = (DEPTH + SRAM_DEPTH - 1) / SRAM_DEPTH;
  localparam int NW     = (WIDTH + SRAM_WIDTH - 1) / SRAM_WIDTH;
  localparam int EAW    = (AWIDTH > SRAM_AWIDTH) ? AWIDTH : SRAM_AWIDTH;

  // Addresses and data zero-extended to whole tiles.
  logic [EAW-1:0]           wa_x;
  logic [EAW-1:0]           ra_x;
  logic [NW*SRAM_WIDTH-1:0] wd_x;
  logic [NW*SRAM_WIDTH-1:0] rd_x;
  logic [SRAM_WIDTH-1:0]    tile_rd [NB][NW];
  logic [NB-1:0]            bank_hit;

  always_comb begin
    wa_x = '0;
    ra_x = '0;
    wd_x = '0;
    wa_x[AWIDTH-1:0] = wr_addr_i;
    ra_x[AWIDTH-1:0] = rd_addr_i;
    wd_x[WIDTH-1:0]  = wr_data_i;
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    for (genvar w = 0; w < NW; w++) begin : g_lane
      trace_sram_2kx8 u_sram (
        .clk_i   (clk_i),
        .we_i    (wr_en_i && bank_hit[b]),
        .waddr_i (wa_x[SRAM_AWIDTH-1:0]),
        .wdata_i (wd_x[w*SRAM_WIDTH +: SRAM_WIDTH]),
        .raddr_i (ra_x[SRAM_AWIDTH-1:0]),
        .rdata_o (tile_rd[b][w])
      );
    end
  end

  if (NB == 1) begin : g_single_bank
    assign bank_hit = 1'b1;
    always_comb begin
      rd_x = '0;
      for (int w = 0; w < NW; w++) begin
        rd_x[w*SRAM_WIDTH +: SRAM_WIDTH] = tile_rd[0][w];
      end
    end
  end else begin : g_multi_bank
    // The bank select must be delayed alongside the registered SRAM address
    // so the output mux picks the bank the data actually came from.
    logic [EAW-SRAM_AWIDTH-1:0] rbank_q;

    always_ff @(posedge clk_i) begin
      rbank_q <= ra_x[EAW-1:SRAM_AWIDTH];
    end

    for (genvar b = 0; b < NB; b++) begin : g_hit
      assign bank_hit[b] = (wa_x[EAW-1:SRAM_AWIDTH] == (EAW-SRAM_AWIDTH)'(b));
    end

    always_comb begin
      rd_x = '0;
      for (int w = 0; w < NW; w++) begin
        rd_x[w*SRAM_WIDTH +: SRAM_WIDTH] = tile_rd[rbank_q][w];
      end
    end
  end

  assign rd_data_o = rd_x[WIDTH-1:0];
endmodule

// File: rtl/debug_trace_capture.sv
// debug_trace_capture: logic-analyser capture buffer. Qualified samples are
// written into a circular buffer of DEPTH words while ARMED; a qualified
// trigger fixes the trigger address and starts a post-trigger countdown, after
// which the buffer freezes in DONE. In IDLE or DONE the buffer can be read
// back by logical index, 0 being the oldest stored sample.
//   clk, resetn        : clock, asynchronous active-low reset
//   bus (slave)        : arm/abort commands, sample stream with trigger,
//                        post_len, status outputs and the readback port
module debug_trace_capture
  import debug_trace_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4096
) (
  input  logic                  clk,
  input  logic                  resetn,
  debug_trace_capture_if.slave  bus
);
  localparam int              AWIDTH = $clog2(DEPTH);
  localparam logic [AWIDTH:0] FULL   = (AWIDTH+1)'(DEPTH);

  state_e            state_q;
  logic [AWIDTH-1:0] wr_ptr_q;
  logic [AWIDTH:0]   fill_q;
  logic              wrapped_q;
  logic [AWIDTH-1:0] trig_addr_q;
  logic [AWIDTH:0]   rem_q;
  logic              done_q;

  logic              rd_p1_q;
  logic              rd_oob_q;
  logic              rd_valid_q;
  logic [WIDTH-1:0]  rd_data_q;

  logic              capturing;
  logic              wr_en;
  logic [31:0]       post_p;
  logic              rd_accept;
  logic              rd_oob;
  logic [AWIDTH-1:0] rd_start;
  logic [AWIDTH-1:0] rd_addr;
  logic [WIDTH-1:0]  mem_rdata;

  assign capturing = (state_q == ST_ARMED) || (state_q == ST_TRIGGERED);
  // abort wins over a sample arriving in the same cycle: nothing is written.
  assign wr_en     = capturing && bus.smp_valid && !bus.abort;
  assign post_p    = clamp_post_len(32'(bus.post_len), 32'(DEPTH));

  // ---------------------------------------------------------------------------
  // Capture FSM and write-side bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      wrapped_q   <= 1'b0;
      trig_addr_q <= '0;
      rem_q       <= '0;
      done_q      <= 1'b0;
    end else if (bus.abort) begin
      // Status of the interrupted capture is kept so it can still be read.
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.arm) begin
            state_q     <= ST_ARMED;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            wrapped_q   <= 1'b0;
            trig_addr_q <= '0;
            done_q      <= 1'b0;
          end
        end
        ST_ARMED, ST_TRIGGERED: begin
          if (bus.smp_valid) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fill_q != FULL) begin
              fill_q <= fill_q + 1'b1;
            end
            if (wr_ptr_q == '1) begin
              wrapped_q <= 1'b1;
            end
            if (state_q == ST_ARMED) begin
              if (bus.trig) begin
                trig_addr_q <= wr_ptr_q;
                rem_q       <= (AWIDTH+1)'(post_p - 32'd1);
                if (post_p == 32'd1) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ST_TRIGGERED;
                end
              end
            end else begin
              // rem counts the post-trigger writes still owed, this one included.
              rem_q <= rem_q - 1'b1;
              if (rem_q == (AWIDTH+1)'(1)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Readback: logical index -> physical address, two-stage pipeline
  // ---------------------------------------------------------------------------
  assign rd_accept = bus.rd_req && !capturing;
  // Before the first wrap the oldest sample sits at 0; after it, the oldest
  // sample is the one about to be overwritten next, at wr_ptr.
  assign rd_start  = wrapped_q ? wr_ptr_q : '0;
  assign rd_addr   = rd_start + bus.rd_idx;
  assign rd_oob    = ({1'b0, bus.rd_idx} >= fill_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_p1_q    <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_p1_q    <= rd_accept;
      rd_oob_q   <= rd_oob;
      rd_valid_q <= rd_p1_q;
      if (rd_p1_q) begin
        rd_data_q <= rd_oob_q ? '0 : mem_rdata;
      end
    end
  end

  trace_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.smp_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (mem_rdata)
  );

  assign bus.state     = state_q;
  assign bus.done      = done_q;
  assign bus.wrapped   = wrapped_q;
  assign bus.fill_cnt  = fill_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: doc/debug_trace_capture.md
Name: debug_trace_capture

Overview:
- Parametrised single-clock logic-analyser capture buffer for the debug subsystem.
- Records WIDTH-bit samples into a circular on-chip memory of DEPTH words, with a runtime-programmable pre/post-trigger split.
- Freezes on completion and offers random-access readback, indexed relative to the oldest stored sample.
- Sits between debug probe muxes and the register/readout bus.

Parameters:
- WIDTH, 16, sample width in bits (1..256)
- DEPTH, 4096, capture depth in words; power of two, at least 2; AWIDTH = log2(DEPTH)

Ports:
- clk  in  1  single system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- arm  in  1  single-cycle pulse that starts a new capture
- abort  in  1  single-cycle pulse that returns the block to IDLE
- smp_valid  in  1  sample qualifier
- smp_data  in  WIDTH  sample
- trig  in  1  trigger; qualified by smp_valid
- post_len  in  AWIDTH+1  samples stored from the trigger onward, trigger sample included
- state  out  2  0=IDLE 1=ARMED 2=TRIGGERED 3=DONE
- done  out  1  high while state is DONE
- wrapped  out  1  buffer has overwritten at least once this capture
- fill_cnt  out  AWIDTH+1  valid words stored, saturates at DEPTH
- trig_addr  out  AWIDTH  physical address of the trigger sample
- rd_req  in  1  read request
- rd_idx  in  AWIDTH  logical index, 0 = oldest sample
- rd_valid  out  1  read data valid
- rd_data  out  WIDTH  read data

Behaviour:
- Reset: state=IDLE. All outputs 0. Internal wr_ptr, post counter and read pipeline cleared. Memory contents are not reset.
- Memory: one write and one read port, both on clk. Read has 1-cycle registered-address latency. Contents persist through IDLE.
- IDLE: no writes. arm -> ARMED.
- Entering ARMED (from IDLE or DONE): wr_ptr, fill_cnt, wrapped, trig_addr and done all cleared.
- ARMED:
  - Each smp_valid writes smp_data at wr_ptr; wr_ptr increments mod DEPTH.
  - fill_cnt increments and saturates at DEPTH.
  - wrapped sets when wr_ptr wraps from DEPTH-1 to 0.
- Trigger: trig & smp_valid in ARMED.
  - The trigger sample is written; trig_addr <= wr_ptr.
  - rem <= P-1, where P = post_len clamped: 0 -> 1, values above DEPTH -> DEPTH. post_len is sampled only in this cycle.
  - If P == 1, next state is DONE; otherwise TRIGGERED.
- TRIGGERED: each smp_valid writes as in ARMED and decrements rem. The write made with rem == 1 is the last one, and the next state is DONE.
- trig outside ARMED, or without smp_valid, is ignored.
- DONE: no writes; done=1. arm -> ARMED (new capture).
- abort in any state -> IDLE next cycle. done clears; fill_cnt, wrapped and trig_addr hold their values.
- Priority: abort over arm. arm in ARMED or TRIGGERED is ignored. A sample arriving in the same cycle as arm from IDLE/DONE is not written.
- Readback:
  - Accepted only in IDLE or DONE. rd_req in ARMED or TRIGGERED is dropped, and rd_valid stays 0.
  - Physical address = (start + rd_idx) mod DEPTH, where start = wr_ptr if wrapped, else 0.
  - rd_valid pulses exactly 2 cycles after rd_req: one cycle for address register plus memory, one for the output register. Fully pipelined; back-to-back requests give back-to-back data.
  - If rd_idx >= fill_cnt: rd_valid=1 and rd_data=0.
  - rd_data holds its value between valid pulses.
  - A read issued in the cycle before an arm still completes.
- Reset mid-operation drops in-flight reads: rd_valid=0 immediately.

Decomposition:
- Package debug_trace_pkg:
  - state encoding constants ST_IDLE/ST_ARMED/ST_TRIGGERED/ST_DONE
  - read latency constant RD_LAT=2
  - clamp function for post_len
- Sub-module trace_mem: parametrised (WIDTH, DEPTH) simple dual-port memory with registered read address, tiled internally over 2Kx8 SRAM primitives in width and depth. The capture FSM, pointers and read pipeline stay in the top module.

Test Plan (WIDTH=8, DEPTH=16):
- Basic pre/post split: arm; samples 0x10..0x14 with trig on 0x12, post_len=3 -> DONE after the 0x14 write, trig_addr=2, fill_cnt=5, wrapped=0. Reads idx 0..4 return 0x10..0x14 two cycles after each rd_req; idx 5 -> rd_data=0 with rd_valid=1.
- Wrap-around: arm; 20 samples 0x00..0x13, trig on 0x13, post_len=1 -> DONE the next cycle, wrapped=1, fill_cnt=16, trig_addr=3. idx0 -> 0x04, idx15 -> 0x13; back-to-back reads give continuous rd_valid.
- Trigger qualification: trig with smp_valid=0 in ARMED -> state stays 1. A second trig in TRIGGERED does not change trig_addr.
- Clamping: post_len=0 behaves as 1. post_len=20 after 4 pre-samples -> 16 post samples, fill_cnt=16, idx0 = the trigger sample.
- Abort and re-arm: abort in TRIGGERED -> state=0, done=0, reads allowed. arm & abort in the same cycle -> IDLE. rd_req in ARMED -> no rd_valid.
- Async reset: resetn low mid-TRIGGERED with a read in flight -> all outputs 0 without a clock edge. After release, state=IDLE and rd_valid never pulses.
